// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus carry flop, LSB first, start/busy/done handshake.
// Latency: WIDTH cycles from the accepted start edge to done; one operation per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is ignored (not queued) otherwise.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb, acc;
  logic             cy;
  logic             cm;
  logic [CW-1:0]    cnt;

  logic s_bit, c_bit, last_bit;

  // Single full-adder slice working on the current LSBs and the running carry.
  always_comb begin
    s_bit    = sa[0] ^ sb[0] ^ cy;
    c_bit    = (sa[0] & sb[0]) | (sa[0] & cy) | (sb[0] & cy);
    last_bit = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting and result load on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      cm   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cy  <= cin;
            cnt <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          acc <= {s_bit, acc[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cy  <= c_bit;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // cy here is the carry into the MSB slice; overflow compares it with the carry out.
            cm   <= cy;
            sum  <= {s_bit, acc[WIDTH-1:1]};
            cout <= c_bit;
            ovf  <= cy ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  // While done is high the overflow flag must equal carry-into-MSB XOR carry-out.
  ovf_consistent: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> (ovf == (cm ^ cout)));

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations.
// Reference model uses plain integer addition and the signed-overflow sign rule.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, overflow when operands share a sign the result lacks.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] esum, output logic ecout, output logic eovf);
    int unsigned total;
    total = int'(ma) + int'(mb) + int'(mc);
    esum  = total[W-1:0];
    ecout = total[W];
    eovf  = (ma[W-1] == mb[W-1]) && (esum[W-1] != ma[W-1]);
  endtask

  // Called just after the start edge; waits for done, counting busy cycles and checking hold.
  task automatic wait_done(output int nbusy, output bit seen);
    logic [W-1:0] held;
    held  = sum;
    nbusy = 0;
    seen  = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("sum_hold", {24'd0, sum}, {24'd0, held});
      if (busy) nbusy++;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic ec, input int nbusy);
    logic [W-1:0] esum;
    logic ecout, eovf;
    model(ea, eb, ec, esum, ecout, eovf);
    chk({tag, "_busy_cycles"}, nbusy, W);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, esum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
  endtask

  // One full operation from a falling edge; inputs scrambled after the start edge.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc);
    int nbusy;
    bit seen;
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    wait_done(nbusy, seen);
    check_result(tag, oa, ob, oc, nbusy);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nbusy;
    bit seen;
    logic [W-1:0] ra, rb;
    logic rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
    end

    do_op("d5a3c", 8'h5A, 8'h3C, 1'b0);
    chk("d5a3c_sum_const", {24'd0, sum}, 32'h96);
    do_op("dff01", 8'hFF, 8'h01, 1'b0);
    chk("dff01_cout_const", {31'd0, cout}, 32'd1);
    do_op("d8080", 8'h80, 8'h80, 1'b1);
    chk("d8080_sum_const", {24'd0, sum}, 32'h01);

    // Start held high through RUN and DONE: no queueing, no operand resampling.
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF;
    wait_done(nbusy, seen);
    check_result("hold1", 8'h12, 8'h34, 1'b0, nbusy);
    @(negedge clk);
    chk("hold_idle_done", {31'd0, done}, 32'd0);
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(nbusy, seen);
    check_result("hold2", 8'hFF, 8'hFF, 1'b0, nbusy);
    @(negedge clk);

    // Reset in the 4th RUN cycle discards the operation.
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
      chk("midrst_no_busy", {31'd0, busy}, 32'd0);
    end
    do_op("after_rst", 8'h01, 8'h02, 1'b0);
    chk("after_rst_sum_const", {24'd0, sum}, 32'h03);

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      do_op("rand", ra, rb, rc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial full adder, the additive counterpart of the team's full subtractor cell. It adds two WIDTH-bit operands plus a carry-in, LSB first, one bit per clock, using a single full-adder slice and a carry flip-flop. It is controlled by a start/busy/done handshake. It sits in the Experiment 2 arithmetic set as the sequential, area-minimal alternative to a ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while an addition is in progress (RUN state).
- done  out  1  one-cycle pulse; result registers updated on the same edge.
- sum  out  WIDTH  registered result; holds its value until the next done.
- cout  out  1  unsigned carry-out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- Internal state:
  - shift registers sa and sb (WIDTH each);
  - accumulator shift register acc (WIDTH);
  - carry flip-flop cy;
  - carry-into-MSB flip-flop cm;
  - bit counter cnt (ceil(log2(WIDTH+1)) bits).
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - When start=1: sa<=a, sb<=b, cy<=cin, cnt<=0, acc<=0, go to RUN.
- RUN: each cycle, the bit slice is:
  - s = sa[0]^sb[0]^cy;
  - c = (sa[0]&sb[0])|(sa[0]&cy)|(sb[0]&cy).
  - Updates on the edge:
    - acc <= {s, acc[WIDTH-1:1]};
    - sa and sb shift right by 1;
    - cy <= c;
    - cnt <= cnt+1.
  - On the cycle where cnt==WIDTH-1, cm <= cy (carry into the MSB slice).
  - On the cycle where cnt==WIDTH-1 (last bit): go to DONE, and load the outputs:
    - sum <= {s, acc[WIDTH-1:1]};
    - cout <= c;
    - ovf <= cy ^ c.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally go to IDLE.
- start is ignored in RUN and DONE. It is not queued. Operands are not resampled.
- a, b and cin may change freely after the accepted start edge.
- Arithmetic is modulo 2^WIDTH, i.e. {cout,sum} = a+b+cin exactly.
- Reset (at any time, including mid-RUN or in DONE):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0;
  - all internal registers cleared;
  - the in-flight operation is discarded.
- rst has priority over start on the same edge.

## Timing
- Edge E0: start=1 is sampled in IDLE. After E0, busy=1.
- Edges E1..E_WIDTH: one bit processed per edge.
- After edge E_WIDTH:
  - sum, cout and ovf are valid;
  - done=1 and busy=0 for one cycle.
- After edge E_(WIDTH+1): done=0, IDLE.
  - The earliest next start is accepted on this edge.
  - Throughput is one operation per WIDTH+2 cycles.
- Latency from the start edge to done high is WIDTH cycles (8 for the default).
- sum, cout and ovf change only on the edge that raises done, or on reset. They are stable at all other times.
- done and busy are never both high. busy is high for exactly WIDTH cycles per operation.

## Test plan
- Reset, then idle for 5 cycles: busy=0, done=0, sum=0x00, cout=0, ovf=0 throughout.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle:
  - busy high for 8 cycles, then done pulse;
  - sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1, ovf=0.
- a=0x80, b=0x80, cin=1 gives sum=0x01, cout=1, ovf=1.
- a=0x12, b=0x34 accepted, then start held high with a=0xFF, b=0xFF during RUN and DONE:
  - the first result is sum=0x46, cout=0;
  - the second operation starts on the edge after DONE and yields sum=0xFE, cout=1.
- Start a=0x0F, b=0x01, assert rst on the 4th RUN cycle for 1 cycle:
  - busy=0, done never pulses, sum=0x00;
  - a following add of 0x01+0x02 gives sum=0x03 after 8 cycles.
- Randomized: 200 random (a, b, cin) operations, each compared against the reference model {cout,sum}=a+b+cin and against the signed overflow rule.
